// File: rtl/operand_decode_stage_pkg.sv
// Shared types and constants for the operand decode stage.
package operand_decode_stage_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic            illegal;
    } alu_bundle_t;

endpackage

// File: rtl/operand_decode_stage_regfile_2r1w.sv
// Integer register file: two combinational reads, one clocked write, x0 hardwired to zero.
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/operand_decode_stage.sv
// RV32I operand decode stage: register read, immediate select, registered ALU bundle.
// Define OPERAND_DECODE_BYPASS_EN to forward same-cycle writeback data into the bundle.
module operand_decode_stage
    import operand_decode_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic            flush_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      func3_o,
    output logic [6:0]      func7_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    logic            valid_q, valid_d;
    alu_bundle_t     bundle_q, bundle_d;
    alu_bundle_t     dec;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            accept;

    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rf_rs1),
        .rdata2_o (rf_rs2),
        .we_i     (wb_en_i),
        .waddr_i  (wb_addr_i),
        .wdata_i  (wb_data_i)
    );

`ifdef OPERAND_DECODE_BYPASS_EN
    assign rs1_val = (wb_en_i && (wb_addr_i != '0) && (wb_addr_i == rs1)) ? wb_data_i : rf_rs1;
    assign rs2_val = (wb_en_i && (wb_addr_i != '0) && (wb_addr_i == rs2)) ? wb_data_i : rf_rs2;
`else
    assign rs1_val = rf_rs1;
    assign rs2_val = rf_rs2;
`endif

    always_comb begin
        dec        = '0;
        dec.opcode = instr_i[6:0];
        dec.func3  = instr_i[14:12];
        dec.func7  = instr_i[31:25];
        dec.rd     = instr_i[11:7];
        case (instr_i[6:0])
            OPCODE_OP: begin
                dec.data1 = rs1_val;
                dec.data2 = rs2_val;
            end
            OPCODE_OP_IMM: begin
                dec.data1 = rs1_val;
                dec.data2 = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign instr_ready_o = !valid_q || out_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    // Flush overrides everything, including an accept in the same cycle.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid_o = valid_q;
    assign data1_o     = bundle_q.data1;
    assign data2_o     = bundle_q.data2;
    assign opcode_o    = bundle_q.opcode;
    assign func3_o     = bundle_q.func3;
    assign func7_o     = bundle_q.func7;
    assign rd_o        = bundle_q.rd;
    assign illegal_o   = bundle_q.illegal;

endmodule

// File: tb/tb_operand_decode_stage.sv
// Bench for operand_decode_stage: directed cases plus randomized traffic against a reference model.
module tb_operand_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic        flush_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic [6:0]  func7_o;
    logic [4:0]  rd_o;
    logic        illegal_o;

    always #5 clk_i = ~clk_i;

    operand_decode_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .instr_i       (instr_i),
        .flush_i       (flush_i),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .data1_o       (data1_o),
        .data2_o       (data2_o),
        .opcode_o      (opcode_o),
        .func3_o       (func3_o),
        .func7_o       (func7_o),
        .rd_o          (rd_o),
        .illegal_o     (illegal_o)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: architectural register array plus one pending bundle.
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_d1, m_d2;
    logic        m_ill;

    localparam logic [31:0] ADD_X7_X5_X6 = 32'h006283B3;
    localparam logic [31:0] ADDI_X1_M1   = 32'hFFF00093;

    function automatic logic [31:0] mk(input int unsigned f7, input int unsigned rs2,
                                       input int unsigned rs1, input int unsigned f3,
                                       input int unsigned rd, input int unsigned op);
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    function automatic logic [31:0] read_src(input int unsigned r);
        logic [31:0] v;
        v = (r == 0) ? 32'h0 : m_regs[r];
`ifdef OPERAND_DECODE_BYPASS_EN
        if (wb_en_i && wb_addr_i != 0 && int'(wb_addr_i) == r) v = wb_data_i;
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 1'b0;
        m_instr = '0;
        m_d1    = '0;
        m_d2    = '0;
        m_ill   = 1'b0;
    endtask

    task automatic model_edge();
        logic acc;
        logic [6:0] op;
        acc = instr_valid_i && (!m_valid || out_ready_i);
        if (acc) begin
            op      = instr_i[6:0];
            m_instr = instr_i;
            if (op == 7'h33) begin
                m_d1 = read_src(instr_i[19:15]);
                m_d2 = read_src(instr_i[24:20]);
                m_ill = 1'b0;
            end else if (op == 7'h13) begin
                m_d1 = read_src(instr_i[19:15]);
                m_d2 = 32'($signed(instr_i[31:20]));
                m_ill = 1'b0;
            end else begin
                m_d1 = 0;
                m_d2 = 0;
                m_ill = 1'b1;
            end
        end
        if (flush_i) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (out_ready_i) m_valid = 1'b0;
        if (wb_en_i && wb_addr_i != 0) m_regs[wb_addr_i] = wb_data_i;
    endtask

    task automatic check_out();
        check("out_valid", out_valid_o, m_valid);
        if (m_valid) begin
            check("data1", data1_o, m_d1);
            check("data2", data2_o, m_d2);
            check("opcode", opcode_o, m_instr[6:0]);
            check("func3", func3_o, m_instr[14:12]);
            check("func7", func7_o, m_instr[31:25]);
            check("rd", rd_o, m_instr[11:7]);
            check("illegal", illegal_o, m_ill);
        end
    endtask

    // One clock: drive, check ready mid-cycle, advance model, check outputs after the edge.
    task automatic cyc(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr_valid_i = iv;
        instr_i       = ins;
        out_ready_i   = ordy;
        flush_i       = fl;
        wb_en_i       = we;
        wb_addr_i     = wa;
        wb_data_i     = wd;
        @(negedge clk_i);
        check("instr_ready", instr_ready_o, !m_valid || ordy);
        model_edge();
        @(posedge clk_i);
        #1;
        check_out();
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", out_valid_o, 0);
        check("rst_data1", data1_o, 0);
        check("rst_data2", data2_o, 0);
        check("rst_opcode", opcode_o, 0);
        check("rst_func3", func3_o, 0);
        check("rst_func7", func7_o, 0);
        check("rst_rd", rd_o, 0);
        check("rst_illegal", illegal_o, 0);
    endtask

    initial begin
        rst_i = 1'b1;
        instr_valid_i = 0; instr_i = 0; flush_i = 0; wb_en_i = 0;
        wb_addr_i = 0; wb_data_i = 0; out_ready_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Operand fetch for OP and OP-IMM, back to back
        cyc(0, 0, 1, 0, 1, 5, 32'h0000_0010);
        cyc(0, 0, 1, 0, 1, 6, 32'hFFFF_FFF0);
        cyc(1, ADD_X7_X5_X6, 1, 0, 0, 0, 0);
        check("add_valid", out_valid_o, 1);
        check("add_data1", data1_o, 32'h10);
        check("add_data2", data2_o, 32'hFFFF_FFF0);
        check("add_rd", rd_o, 7);
        check("add_illegal", illegal_o, 0);
        cyc(1, ADDI_X1_M1, 1, 0, 0, 0, 0);
        check("addi_data1", data1_o, 0);
        check("addi_data2", data2_o, 32'hFFFF_FFFF);

        // Stall for three cycles, then release with a new instruction
        cyc(1, ADD_X7_X5_X6, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, ADDI_X1_M1, 0, 0, 0, 0, 0);
            check("stall_ready", instr_ready_o, 0);
            check("stall_data2", data2_o, 32'hFFFF_FFF0);
        end
        cyc(1, ADDI_X1_M1, 1, 0, 0, 0, 0);
        check("release_valid", out_valid_o, 1);
        check("release_data2", data2_o, 32'hFFFF_FFFF);

        // Same-cycle writeback to a source register
        cyc(1, ADD_X7_X5_X6, 1, 0, 1, 5, 32'hA5A5_A5A5);
`ifdef OPERAND_DECODE_BYPASS_EN
        check("bypass_data1", data1_o, 32'hA5A5_A5A5);
`else
        check("bypass_data1", data1_o, 32'h10);
`endif
        cyc(0, 0, 1, 0, 0, 0, 0);
        check("drain_valid", out_valid_o, 0);

        // x0 stays zero; non-OP opcodes are flagged illegal
        cyc(0, 0, 1, 0, 1, 0, 32'hDEAD_BEEF);
        cyc(1, mk(0, 6, 0, 0, 7, 7'h33), 1, 0, 0, 0, 0);
        check("x0_data1", data1_o, 0);
        cyc(1, mk(0, 6, 5, 2, 7, 7'h03), 1, 0, 0, 0, 0);
        check("load_illegal", illegal_o, 1);
        check("load_data1", data1_o, 0);
        check("load_data2", data2_o, 0);

        // Flush of a held bundle, then flush alongside accept and write
        cyc(1, ADD_X7_X5_X6, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        check("flush_valid", out_valid_o, 0);
        cyc(1, ADD_X7_X5_X6, 1, 1, 1, 6, 32'h77);
        check("flush_acc_valid", out_valid_o, 0);
        cyc(1, ADD_X7_X5_X6, 1, 0, 0, 0, 0);
        check("flush_wr_data2", data2_o, 32'h77);

        // Asynchronous reset in the middle of a stall
        cyc(1, ADD_X7_X5_X6, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        #1;
        check("async_rst_valid", out_valid_o, 0);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        cyc(1, ADD_X7_X5_X6, 1, 0, 0, 0, 0);
        check("post_rst_x5", data1_o, 0);

        // Randomized traffic over a small register window to exercise hazards
        for (int n = 0; n < 400; n++) begin
            int unsigned sel;
            int unsigned op;
            logic [31:0] ins;
            sel = $urandom_range(0, 9);
            op  = (sel < 4) ? 32'h33 : (sel < 8) ? 32'h13 : $urandom_range(0, 127);
            ins = mk($urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 31), op);
            cyc($urandom_range(0, 9) < 7, ins, $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 7)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_decode_stage.md
Name: operand_decode_stage

Overview:
- Stage directly upstream of the ALU: accepts a 32-bit RV32I instruction and decodes opcode/func3/func7/rd.
- Holds the 32x32 integer register file, with a read port pair for rs1/rs2 and a write port from writeback.
- Selects data2 as rs2 or the sign-extended I-immediate.
- Presents a registered ALU operand bundle behind a valid/ready handshake.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, register count; x0 is hardwired to zero

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- instr_valid_i  in  1  instruction present
- instr_ready_o  out  1  stage can accept the instruction this cycle
- instr_i  in  32  instruction word
- flush_i  in  1  synchronous kill of the held bundle and of any instruction accepted this cycle
- wb_en_i  in  1  register file write enable
- wb_addr_i  in  5  write address
- wb_data_i  in  XLEN  write data
- out_valid_o  out  1  bundle valid toward the ALU
- out_ready_i  in  1  ALU/execute side accepts the bundle
- data1_o  out  XLEN  rs1 value
- data2_o  out  XLEN  rs2 value or immediate
- opcode_o  out  7  instr[6:0]
- func3_o  out  3  instr[14:12]
- func7_o  out  7  instr[31:25]
- rd_o  out  5  instr[11:7]
- illegal_o  out  1  opcode is neither OP nor OP-IMM

Behaviour:
- Reset: all bundle outputs clear to 0, including out_valid_o and illegal_o. All register file entries clear to 0. Reset is asynchronous and takes effect mid-handshake; any held bundle is lost.
- Ready rule:
  - instr_ready_o = !out_valid_o || out_ready_i, purely combinational.
  - instr_ready_o does not depend on instr_valid_i.
- Accept: when instr_valid_i && instr_ready_o, the decoded bundle is registered on the next edge. out_valid_o rises one cycle later, so latency is 1 cycle.
- Hold: while out_valid_o && !out_ready_i, every bundle output is stable, bit for bit.
- Drain: when out_ready_i is high and no new accept occurs, out_valid_o falls on the next edge. Accepting while draining gives back-to-back throughput of 1 per cycle.
- Flush:
  - flush_i high forces out_valid_o to 0 on the next edge.
  - An instruction accepted in the same cycle is consumed and discarded.
  - Register file writes in that cycle still occur.
- Decode:
  - OP (0110011): data2 = rs2 value.
  - OP-IMM (0010011): data2 = sign-extended instr[31:20]. func7_o still carries the raw instr[31:25]; the ALU interprets it using the opcode.
  - Any other opcode: illegal_o = 1, data1 = 0, data2 = 0, and the bundle still flows through the handshake.
- Register file:
  - Reads of x0 always return 0.
  - A write with wb_addr_i == 0 is ignored.
  - Writes commit on the clock edge, independent of the handshake and of stall.
- Width: XLEN-bit operands. No arithmetic is performed here besides sign extension.
- Same-cycle write and read of the same nonzero register: behaviour is set by the optional feature below.

Optional Feature:
- Macro: OPERAND_DECODE_BYPASS_EN.
- Defined: if wb_en_i && wb_addr_i != 0 && wb_addr_i == rs1 (or rs2) in the accept cycle, the bundle captures wb_data_i (write-through bypass).
- Undefined: the bundle captures the pre-write register value, and software or the hazard unit must separate the producer and consumer by at least one cycle.

Decomposition:
- Shared package (simply5_pkg or equivalent) holds:
  - OPCODE_OP and OPCODE_OP_IMM localparams
  - XLEN
  - a packed struct alu_bundle_t {data1, data2, opcode, func3, func7, rd, illegal}
- One sub-module, regfile_2r1w: two combinational read ports, one synchronous write port, async-reset storage, x0 hardwired. Bypass muxing stays in the parent.

Test Plan:
- Write x5=32'h0000_0010 and x6=32'hFFFF_FFF0, then issue OP ADD x7,x5,x6 (32'h006283B3) -> next cycle out_valid_o=1, data1_o=32'h10, data2_o=32'hFFFF_FFF0, rd_o=7, illegal_o=0.
- OP-IMM ADDI x1,x0,-1 (32'hFFF00093) -> data1_o=0, data2_o=32'hFFFF_FFFF.
- Hold out_ready_i=0 for 3 cycles after accepting 32'h006283B3 -> instr_ready_o=0, bundle unchanged; raise out_ready_i with a new valid instruction -> the next bundle appears the following cycle with no bubble.
- Same cycle: wb_en_i=1, wb_addr_i=5, wb_data_i=32'hA5A5_A5A5, and an accept of an ADD using rs1=x5 -> with the macro, data1_o=32'hA5A5_A5A5; without it, data1_o equals the old x5 value.
- Write x0 with 32'hDEAD_BEEF, then read x0 -> data1_o=0. Opcode 0000011 (load) -> illegal_o=1, data1_o=data2_o=0.
- Assert flush_i during a held bundle; separately, assert rst_i mid-stall with x5 non-zero -> out_valid_o=0 next edge (flush) or immediately (reset), and x5 reads 0 after reset.
